// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, FSM encoding, line table and pick priority for the tic-tac-toe player
package ttt_pkg;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SCAN_WIN   = 3'd1;
    localparam logic [2:0] S_SCAN_BLOCK = 3'd2;
    localparam logic [2:0] S_PICK       = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_ACK   = 3'd5;
    localparam logic [2:0] S_FINISH     = 3'd6;

    localparam int ACK_TIMEOUT = 16;

    // Cell indices (3*row + col) of each line: rows, columns, main diagonal, anti-diagonal
    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    // Fallback order: centre, corners, then edges
    localparam logic [3:0] PICK_ORDER [9] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    function automatic logic [1:0] cell_code(input logic [17:0] b, input logic [3:0] i);
        logic [4:0] sh;
        sh = 5'd16 - {i, 1'b0};
        return b[sh +: 2];
    endfunction

    function automatic logic [3:0] cell_col(input logic [3:0] i);
        return i % 4'd3;
    endfunction

    function automatic logic [3:0] cell_row(input logic [3:0] i);
        return i / 4'd3;
    endfunction
endpackage

// File: rtl/ttt_if.sv
// ttt_if: board/request inputs and move/status outputs between game controller and auto player
interface ttt_if;
    logic [17:0] board;
    logic [1:0]  player;
    logic        go;
    logic [3:0]  x_out;
    logic [3:0]  y_out;
    logic        make_move;
    logic        busy;
    logic        done;
    logic        no_move;
    logic        error;

    modport master (
        output board, player, go,
        input  x_out, y_out, make_move, busy, done, no_move, error
    );

    modport slave (
        input  board, player, go,
        output x_out, y_out, make_move, busy, done, no_move, error
    );
endinterface

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: flags a line holding two target cells and one empty cell, and where the empty one is
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    input  logic [1:0] target,
    output logic       hit,
    output logic [1:0] pos
);
    // Occupied (11) cells never equal a valid target, so they simply block the line
    always_comb begin
        hit = (a == EMPTY && b == target && c == target) ||
              (a == target && b == EMPTY && c == target) ||
              (a == target && b == target && c == EMPTY);
        pos = (a == EMPTY) ? 2'd0 : (b == EMPTY) ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/ttt_auto_player.sv
// ttt_auto_player: picks a win, block or priority cell from a board snapshot and issues the move
module ttt_auto_player
    import ttt_pkg::*;
(
    input logic  clk,
    input logic  rst_n,
    ttt_if.slave bus
);
    logic [2:0]  state_q, state_d;
    logic [17:0] snap_q, snap_d;
    logic [1:0]  player_q, player_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        no_move_q, no_move_d;
    logic        error_q, error_d;

    logic [1:0]  ca, cb, cc, target, pos;
    logic        hit, pick_found, ack;
    logic [3:0]  line_cell, pick_cell;

    assign target = (state_q == S_SCAN_WIN) ? player_q : ~player_q;
    assign ca = cell_code(snap_q, LINES[idx_q][0]);
    assign cb = cell_code(snap_q, LINES[idx_q][1]);
    assign cc = cell_code(snap_q, LINES[idx_q][2]);
    assign line_cell = LINES[idx_q][pos];
    assign ack = cell_code(bus.board, y_q * 4'd3 + x_q) == player_q;

    ttt_line_eval u_eval (
        .a      (ca),
        .b      (cb),
        .c      (cc),
        .target (target),
        .hit    (hit),
        .pos    (pos)
    );

    // Highest-priority empty cell; scanning backwards leaves the first match in order
    always_comb begin
        pick_found = 1'b0;
        pick_cell  = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (cell_code(snap_q, PICK_ORDER[i]) == EMPTY) begin
                pick_found = 1'b1;
                pick_cell  = PICK_ORDER[i];
            end
        end
    end

    // Move-selection FSM: one line per cycle in each scan phase, then pick, issue and await ack
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        player_d  = player_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        no_move_d = no_move_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    if (bus.player == P1 || bus.player == P2) begin
                        snap_d   = bus.board;
                        player_d = bus.player;
                        idx_d    = 3'd0;
                        state_d  = S_SCAN_WIN;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_SCAN_WIN, S_SCAN_BLOCK: begin
                if (hit) begin
                    x_d     = cell_col(line_cell);
                    y_d     = cell_row(line_cell);
                    state_d = S_ISSUE;
                end else if (idx_q == 3'd7) begin
                    idx_d   = 3'd0;
                    state_d = (state_q == S_SCAN_WIN) ? S_SCAN_BLOCK : S_PICK;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_PICK: begin
                if (pick_found) begin
                    x_d     = cell_col(pick_cell);
                    y_d     = cell_row(pick_cell);
                    state_d = S_ISSUE;
                end else begin
                    no_move_d = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            S_ISSUE: begin
                cnt_d   = 4'd1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    state_d = S_FINISH;
                end else if (cnt_q == 4'(ACK_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FINISH: begin
                no_move_d = 1'b0;
                error_d   = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset aborts any move in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            player_q  <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            no_move_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            player_q  <= player_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            no_move_q <= no_move_d;
            error_q   <= error_d;
        end
    end

    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.make_move = state_q == S_ISSUE;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.done      = state_q == S_FINISH;
    assign bus.no_move   = no_move_q;
    assign bus.error     = error_q;
endmodule

// File: doc/ttt_auto_player.md
TTT_AUTO_PLAYER -- requirements
Module: ttt_auto_player

Interface
REQ-001 SHALL use a single clock; reset is asynchronous and active-low, named clk and rst_n as in the rest of the codebase.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 board  input  18  live game board, row-major; cell (r,c) at bits [17-2*(3r+c) -: 2]; 00 empty, 01 P1, 10 P2, 11 occupied.
REQ-005 player  input  2  own cell code (01 or 10); opponent code is the bitwise inverse.
REQ-006 go  input  1  request one move; sampled only in IDLE.
REQ-007 x_out, y_out  output  4 each  chosen column and row (0-2), registered.
REQ-008 make_move  output  1  one-cycle move strobe to the game controller.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done, no_move, error  output  1 each  one-cycle completion/status pulses.

Function
REQ-011 States SHALL be IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE, WAIT_ACK, FINISH.
REQ-012 IDLE: go=1 with player 01/10 -> snapshot board, line index=0, enter SCAN_WIN; go=1 with player 00/11 -> FINISH with error=1.
REQ-013 Cycle 1 = first cycle after the edge sampling go; SCAN_WIN evaluates line k in cycle k+1.
REQ-014 Line order: rows 0-2 (idx 0-2), columns 0-2 (idx 3-5), main diagonal (6), anti-diagonal (7).
REQ-015 Line hit = exactly two cells equal the target code and one cell 00; target = player in SCAN_WIN, opponent in SCAN_BLOCK; first hit in index order wins.
REQ-016 Hit on line k of SCAN_WIN -> ISSUE in cycle k+2; no hit after idx 7 -> SCAN_BLOCK, idx 0, cycles 9-16.
REQ-017 Hit on line m of SCAN_BLOCK -> ISSUE in cycle 10+m; no hit -> PICK in cycle 17.
REQ-018 PICK: first empty snapshot cell in order (1,1), (0,0), (0,2), (2,0), (2,2), (0,1), (1,0), (1,2), (2,1) -> ISSUE in cycle 18.
REQ-019 PICK with no empty cell -> FINISH with no_move=1; make_move SHALL NOT assert.
REQ-020 ISSUE: make_move=1 for exactly one cycle; x_out/y_out valid in that cycle and held until the next ISSUE.
REQ-021 WAIT_ACK: live board cell at (y_out,x_out) == player -> FINISH; 16 cycles without that -> FINISH with error=1.
REQ-022 FINISH: done=1 for one cycle together with any no_move/error; next state IDLE.
REQ-023 go while busy SHALL be ignored, not queued.
REQ-024 Board changes after the snapshot SHALL NOT affect scan or pick results.
REQ-025 11 cells count as occupied and never match a target code.

Reset
REQ-026 rst_n low SHALL force IDLE and clear snapshot and line index; x_out, y_out=0; make_move, busy, done, no_move, error=0.
REQ-027 Reset asserted mid-operation SHALL abort immediately with no make_move or done pulse.

Structure
REQ-028 Shared package ttt_pkg SHALL hold: cell codes EMPTY/P1/P2; state encoding; 8x3 line-to-cell index table; ACK_TIMEOUT=16; the PICK priority list.
REQ-029 Sub-module ttt_line_eval SHALL be combinational: inputs are three cell codes and the target code; outputs are hit and the empty position (0-2).

Verification
REQ-030 Empty board, player=01, go -> PICK; make_move in cycle 18 with x=1, y=1; board ack -> done in the next FINISH cycle.
REQ-031 Cells (0,0) and (0,1)=01, player=01 -> make_move in cycle 2 with x=2, y=0.
REQ-032 Cells (0,0) and (1,0)=10, player=01, no own pair -> column-0 block hit (m=3); make_move in cycle 13 with x=0, y=2.
REQ-033 Full board with no empty cell -> done and no_move in the same cycle; make_move never asserted.
REQ-034 Move issued, board never updated -> error and done 16 cycles after make_move; go pulses during busy produce no second make_move.
REQ-035 rst_n pulsed low in cycle 5 of SCAN_WIN -> IDLE; all outputs 0; no make_move or done until the next go.
